// File: rtl/leg_pkg.sv
// Shared types and constants for the UART/MMIO slice.
// Optional overwrite-on-full for the RX FIFO is enabled by RX_FIFO_OVERWRITE_EN.
package leg_pkg;
    typedef logic [7:0] byte_t;

    localparam int RX_FIFO_DEPTH_DEFAULT = 4;

    localparam logic [15:0] MMIO_UART_TX   = 16'hFFFF;
    localparam logic [15:0] MMIO_UART_RX   = 16'hFFFE;
    localparam logic [15:0] MMIO_UART_STAT = 16'hFFFD;
endpackage

// File: rtl/uart_rx_fifo_ptr.sv
// Wrap-bit pointer counter for the RX FIFO: W bits, MSB toggles on each lap.
module fifo_ptr #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_inc) ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with first-word-fall-through output and sticky overrun.
// Define RX_FIFO_OVERWRITE_EN to keep the newest bytes when a push hits a full FIFO.
module uart_rx_fifo
    import leg_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = RX_FIFO_DEPTH_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_valid,
    output logic [7:0]             o_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic [RX_FIFO_DEPTH:0] o_level,
    output logic                   o_rx_present,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun
);
    localparam int D = RX_FIFO_DEPTH;

    byte_t        mem_q [2**D];
    logic [D:0]   wr_ptr;
    logic [D:0]   rd_ptr;
    logic         empty;
    logic         full;
    logic         pop;
    logic         push_ok;
    logic         ovf;
    logic         wr_inc;
    logic         rd_inc;
    logic         overrun_q;
    logic         overrun_d;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[D-1:0] == rd_ptr[D-1:0]) && (wr_ptr[D] != rd_ptr[D]);
    assign pop     = i_rd_ready && !empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO is then legal.
    assign push_ok = i_rx_valid && (!full || pop);
    assign ovf     = i_rx_valid && full && !pop;

`ifdef RX_FIFO_OVERWRITE_EN
    // Overwrite the oldest slot and advance both pointers so level stays at max.
    assign wr_inc = push_ok || ovf;
    assign rd_inc = pop || ovf;
`else
    assign wr_inc = push_ok;
    assign rd_inc = pop;
`endif

    fifo_ptr #(.W(D + 1)) u_wr_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (wr_inc),
        .o_ptr (wr_ptr)
    );

    fifo_ptr #(.W(D + 1)) u_rd_ptr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (rd_inc),
        .o_ptr (rd_ptr)
    );

    always_ff @(posedge i_clk) begin
        if (wr_inc) mem_q[wr_ptr[D-1:0]] <= i_rx_data;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (i_clr_overrun) overrun_d = 1'b0;
        if (ovf)           overrun_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) overrun_q <= 1'b0;
        else       overrun_q <= overrun_d;
    end

    assign o_data       = empty ? 8'h00 : mem_q[rd_ptr[D-1:0]];
    assign o_rd_valid   = !empty;
    assign o_rx_present = !empty;
    assign o_level      = wr_ptr - rd_ptr;
    assign o_overrun    = overrun_q;
endmodule
